// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Contents:
//   DEFAULT_DATASIZE / DEFAULT_MIN_DIV - default frame width and minimum divider
//   rx_state_t                         - receiver FSM state encoding
//   eff_div()                          - clamps the requested bit period to the minimum
package uart_pkg;

  localparam int DEFAULT_DATASIZE = 20;
  localparam int DEFAULT_MIN_DIV  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  function automatic logic [31:0] eff_div(input logic [31:0] cpb, input logic [31:0] min_div);
    return (cpb < min_div) ? min_div : cpb;
  endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Word-side bus between the UART receiver and the RX FIFO.
// Signals:
//   data_o        - received word, LSB received first
//   valid_o       - data_o holds an unconsumed word
//   ready_i       - FIFO accepts the word
//   framing_err_o - one-cycle pulse, stop bit sampled low
//   overrun_o     - one-cycle pulse, frame dropped while a word was pending
//   busy_o        - receiver FSM not idle
// Modports: master = receiver side, slave = FIFO side.
interface uart_rx_deserializer_if
  import uart_pkg::*;
#(
  parameter int DATASIZE = DEFAULT_DATASIZE
) ();

  logic [DATASIZE-1:0] data_o;
  logic                valid_o;
  logic                ready_i;
  logic                framing_err_o;
  logic                overrun_o;
  logic                busy_o;

  modport master (
    output data_o,
    output valid_o,
    output framing_err_o,
    output overrun_o,
    output busy_o,
    input  ready_i
  );

  modport slave (
    input  data_o,
    input  valid_o,
    input  framing_err_o,
    input  overrun_o,
    input  busy_o,
    output ready_i
  );

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Ports:
//   clk - system clock
//   rst - asynchronous reset, active high; both flops reset to 1 (idle line)
//   d   - asynchronous input
//   q   - synchronized output
module uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: 1 start bit, DATASIZE data bits LSB first, 1 stop bit, no parity.
// The bit period N = max(clk_per_bit_i, MIN_DIV) is captured at frame start; bits
// are sampled mid-period relative to the detected falling edge of the start bit.
// Ports:
//   avl_clk_i     - system clock
//   avl_reset_i   - asynchronous reset, active high
//   rx_i          - serial line, asynchronous, idle high
//   clk_per_bit_i - bit period in avl_clk_i cycles
//   avl           - word-side bus (data/valid/ready, error pulses, busy)
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DATASIZE = DEFAULT_DATASIZE,
  parameter int MIN_DIV  = DEFAULT_MIN_DIV
) (
  input  logic                          avl_clk_i,
  input  logic                          avl_reset_i,
  input  logic                          rx_i,
  input  logic [31:0]                   clk_per_bit_i,
  uart_rx_deserializer_if.master        avl
);

  localparam int                IDX_W    = $clog2(DATASIZE + 2);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATASIZE - 1);

  logic                rx_s;
  logic                rx_d;
  logic [2:0]          settle;
  logic                fall;

  rx_state_t           state;
  logic [31:0]         n_lat;
  logic [31:0]         cnt;
  logic [IDX_W-1:0]    idx;
  logic [DATASIZE-1:0] shreg;
  logic [DATASIZE-1:0] data_r;
  logic                valid_r;
  logic                ferr_r;
  logic                ovr_r;
  logic                busy_r;

  uart_sync u_sync (
    .clk (avl_clk_i),
    .rst (avl_reset_i),
    .d   (rx_i),
    .q   (rx_s)
  );

  // The synchronizer comes out of reset holding 1 regardless of the line. If the
  // line is low at release (reset hit mid-frame) that would look like a falling
  // edge, so edges are only trusted once rx_s and rx_d both carry real line values.
  always_ff @(posedge avl_clk_i or posedge avl_reset_i) begin
    if (avl_reset_i) begin
      rx_d   <= 1'b1;
      settle <= 3'b000;
    end else begin
      rx_d   <= rx_s;
      settle <= {settle[1:0], 1'b1};
    end
  end

  assign fall = settle[2] & rx_d & ~rx_s;

  // Receiver FSM. cnt holds the cycle offset inside the current phase: in START it
  // counts from t0, in DATA/STOP it restarts at 1 after each sample point.
  always_ff @(posedge avl_clk_i or posedge avl_reset_i) begin
    if (avl_reset_i) begin
      state   <= ST_IDLE;
      n_lat   <= 32'd0;
      cnt     <= 32'd0;
      idx     <= '0;
      shreg   <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      ovr_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      ferr_r <= 1'b0;
      ovr_r  <= 1'b0;

      if (valid_r && avl.ready_i) begin
        valid_r <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (fall) begin
            state  <= ST_START;
            busy_r <= 1'b1;
            n_lat  <= eff_div(clk_per_bit_i, 32'(MIN_DIV));
            cnt    <= 32'd1;
            idx    <= '0;
          end
        end

        ST_START: begin
          if (cnt == {1'b0, n_lat[31:1]}) begin
            if (rx_s) begin
              // Line already back high at mid start bit: glitch, not a frame.
              state  <= ST_IDLE;
              busy_r <= 1'b0;
            end else begin
              state <= ST_DATA;
              cnt   <= 32'd1;
              idx   <= '0;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        ST_DATA: begin
          if (cnt == n_lat) begin
            shreg <= {rx_s, shreg[DATASIZE-1:1]};
            cnt   <= 32'd1;
            if (idx == LAST_IDX) begin
              state <= ST_STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        ST_STOP: begin
          if (cnt == n_lat) begin
            state  <= ST_IDLE;
            busy_r <= 1'b0;
            if (!rx_s) begin
              ferr_r <= 1'b1;
            end else if (!valid_r || avl.ready_i) begin
              // A handshake in this same cycle frees the slot for the new word.
              data_r  <= shreg;
              valid_r <= 1'b1;
            end else begin
              ovr_r <= 1'b1;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        default: begin
          state  <= ST_IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign avl.data_o        = data_r;
  assign avl.valid_o       = valid_r;
  assign avl.framing_err_o = ferr_r;
  assign avl.overrun_o     = ovr_r;
  assign avl.busy_o        = busy_r;

endmodule

// File: doc/uart_rx_deserializer.md
UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

Interface
REQ-001 SHALL have parameter DATASIZE, default 20: data bits per frame; it matches the word width of the Avalon UART interface RX FIFO.
REQ-002 SHALL have parameter MIN_DIV, default 4: smallest honoured clocks-per-bit value.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: avl_clk_i  input  1  system clock, rising edge.
REQ-004 SHALL have port avl_reset_i  input  1  asynchronous reset, active high.
REQ-005 SHALL have port rx_i  input  1  serial line, asynchronous, idle high.
REQ-006 SHALL have port clk_per_bit_i  input  32  bit period in avl_clk_i cycles, from the interface register.
REQ-007 SHALL have port data_o  output  DATASIZE  received word, LSB received first.
REQ-008 SHALL have port valid_o  output  1  data_o holds an unconsumed word.
REQ-009 SHALL have port ready_i  input  1  RX FIFO accepts the word (FIFO not full).
REQ-010 SHALL have port framing_err_o  output  1  one-cycle pulse, stop bit sampled low.
REQ-011 SHALL have port overrun_o  output  1  one-cycle pulse, frame dropped because valid_o was still pending.
REQ-012 SHALL have port busy_o  output  1  FSM not in IDLE.

Function
REQ-013 SHALL pass rx_i through a 2-flop synchronizer; all decisions use the synchronized line rx_s.
REQ-014 SHALL use frame format: 1 start bit (low), DATASIZE data bits LSB first, 1 stop bit (high), no parity.
REQ-015 SHALL latch N = max(clk_per_bit_i, MIN_DIV) on leaving IDLE; changes to clk_per_bit_i mid-frame SHALL have no effect until the next frame.
REQ-016 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-017 SHALL leave IDLE for START on a high-to-low transition of rx_s; the cycle this transition is detected is t0.
REQ-018 SHALL sample at the following points: start bit at t0+floor(N/2); data bit k (k=0..DATASIZE-1) at t0+floor(N/2)+(k+1)*N; stop bit at t0+floor(N/2)+(DATASIZE+1)*N.
REQ-019 SHALL treat rx_s high at the start-bit sample point as a false start and return to IDLE with no output activity.
REQ-020 SHALL, in DATA, shift each sample into a DATASIZE-bit shift register and move to STOP after bit DATASIZE-1.
REQ-021 SHALL, on stop bit high with valid_o low, load data_o and assert valid_o in the next cycle, then return to IDLE.
REQ-022 SHALL, on stop bit low, pulse framing_err_o for one cycle, leave data_o and valid_o unchanged, and return to IDLE.
REQ-023 SHALL, on stop bit high with valid_o still high, pulse overrun_o for one cycle, keep the old data_o, and drop the new word.
REQ-024 SHALL hold valid_o and data_o stable until a cycle with valid_o and ready_i both high; valid_o SHALL clear in the next cycle.
REQ-025 SHALL give precedence to the handshake when a handshake and a new frame completion occur in the same cycle: no overrun, the new word is loaded, and valid_o stays high.
REQ-026 SHALL allow a new start bit to be detected in IDLE in the first cycle after the stop-bit sample (back-to-back frames).
REQ-027 SHALL keep the bit-period counter and bit index wide enough for 32-bit N and DATASIZE+2 bits respectively, with no wrap-around within a frame.

Reset
REQ-028 SHALL, while avl_reset_i is high, force: FSM IDLE, data_o 0, valid_o 0, framing_err_o 0, overrun_o 0, busy_o 0, synchronizer flops 1.
REQ-029 SHALL abort a frame cleanly on reset mid-frame; after release the block SHALL wait for a fresh falling edge and SHALL NOT emit a partial word.

Structure
REQ-030 SHALL place the FSM state enum and default DATASIZE/MIN_DIV constants in shared package uart_pkg.
REQ-031 SHALL implement the 2-flop synchronizer as sub-module uart_sync, reset value 1.

Verification
REQ-032 SHALL cover: N=8, ready_i=1, frame data 20'hA5A5A -> valid_o one cycle after stop sample, data_o=20'hA5A5A, handshake same cycle.
REQ-033 SHALL cover: 3-cycle low glitch on rx_i, N=8 -> no valid_o, no error pulse, FSM back to IDLE.
REQ-034 SHALL cover: frame 20'h00001 with stop bit 0 -> framing_err_o single pulse, valid_o stays 0.
REQ-035 SHALL cover: ready_i=0, two frames 20'h12345 then 20'h6789A -> data_o=20'h12345, overrun_o pulse at second stop; ready_i=1 then clears valid_o.
REQ-036 SHALL cover: clk_per_bit_i=2 -> frame decoded with N=4; clk_per_bit_i changed 16->8 mid-frame -> frame still decoded at 16.
REQ-037 SHALL cover: avl_reset_i pulse at data bit 10 -> all outputs 0; next clean frame 20'hFFFFF decoded correctly.
